multicycle_control_unit: RTL
============================

Name: multicycle_control_unit

Overview:
- Multi-cycle successor to the single-cycle RV32I main decoder.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB states and drives the shared-memory, PC, IR and register-file enables.
- Handshakes with a single unified memory port that may insert wait states.
- Maintains a retired-instruction counter and latches a sticky illegal-opcode halt.

Parameters:
- ALU_OP_W, 2, width of alu_op. Encoding: 00 ADD, 01 SUB/compare, 10 funct-decoded; upper bits zero.
- CNT_W, 32, width of retire_cnt.
- TIMEOUT_CYCLES, 255, maximum memory wait cycles before fault. Used only with MCU_MEM_TIMEOUT_EN.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- opcode  in  7  IR[6:0]; stable from the DECODE state onward
- funct3  in  3  IR[14:12]
- mem_ready  in  1  memory has completed the current request this cycle
- mem_req  out  1  memory request valid
- mem_we  out  1  write request (qualified by mem_req)
- mem_size  out  2  access width, equal to funct3[1:0] in MEM, 2'b10 in FETCH
- iord  out  1  memory address source: 0 = PC, 1 = ALU result
- ir_write  out  1  capture memory read data into IR
- pc_write  out  1  unconditional PC update
- pc_src  out  2  00 PC+4, 01 branch/JAL target, 10 JALR target
- branch  out  1  conditional PC update, qualified by the ALU flag externally
- alu_src  out  1  ALU B input: 1 = immediate, 0 = register
- alu_op  out  ALU_OP_W  ALU operation class
- mem_to_reg  out  1  writeback data from memory
- reg_write  out  1  register-file write enable
- lui, auipc, jal, jalr  out  1 each  instruction-class flags, valid in EXEC and WB
- state  out  3  current state, for debug
- halted  out  1  sticky; set on illegal opcode or timeout
- retire_cnt  out  CNT_W  count of instructions retired

Behaviour:
- Clocking and reset: single clock, reset is synchronous, active-high, on clk.
- While rst is high, all outputs are gated to 0. On the next edge: state = FETCH (0), halted = 0, retire_cnt = 0, class register cleared.
- A reset asserted mid-instruction abandons that instruction. It is not counted.
- State encodings: FETCH 0, DECODE 1, EXEC 2, MEM 3, WB 4, HALT 5. Codes 6 and 7 go to HALT.
- Outputs are Moore-style: a function of state, the class latched in DECODE, and mem_ready only where stated.
- FETCH: mem_req = 1, iord = 0, mem_we = 0.
  - When mem_ready = 1 in the same cycle: ir_write = 1, pc_write = 1, pc_src = 00. Next state DECODE.
  - Otherwise hold FETCH.
- DECODE: latch the class from opcode. Classes: R, I, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC.
  - Unknown opcode: next state HALT, set halted.
  - Otherwise next state EXEC. No other outputs asserted.
- EXEC:
  - R: alu_op = 10.
  - I: alu_op = 10, alu_src = 1.
  - LOAD/STORE: alu_op = 00, alu_src = 1.
  - BRANCH: alu_op = 01, branch = 1, pc_src = 01.
  - JAL: jal = 1, pc_write = 1, pc_src = 01.
  - JALR: jalr = 1, alu_src = 1, pc_write = 1, pc_src = 10.
  - LUI: lui = 1.
  - AUIPC: auipc = 1, alu_src = 1.
  - Next state: LOAD/STORE to MEM; BRANCH to FETCH (retire); all others to WB.
- JAL/JALR link value: rd is written with the old PC+4, taken externally from the PC register captured before the EXEC update.
- MEM: mem_req = 1, iord = 1, mem_we = (STORE), mem_size = funct3[1:0].
  - Hold until mem_ready.
  - Then LOAD goes to WB; STORE goes to FETCH (retire).
- WB: reg_write = 1, mem_to_reg = (LOAD), and the class flag stays asserted. Next state FETCH (retire).
- Retire: retire_cnt increments by 1 on every transition into FETCH from EXEC, MEM or WB. Wraps modulo 2^CNT_W.
- HALT: all enables 0, halted = 1. Remains in HALT until rst.
- Latency (zero wait states):
  - branch: 3 cycles
  - R, I, JAL, JALR, LUI, AUIPC, store: 4 cycles
  - load: 5 cycles
  - Each memory wait cycle adds 1.
- Control flags are never asserted outside their stated states.
- mem_req stays high continuously while waiting. The request attributes do not change until mem_ready.

Optional Feature:
- MCU_MEM_TIMEOUT_EN defined:
  - A wait counter clears on entry to FETCH or MEM and counts cycles with mem_req = 1 and mem_ready = 0.
  - When the counter reaches TIMEOUT_CYCLES, the next state is HALT and halted is set.
  - A mem_ready arriving in the same cycle as the limit wins: no fault.
- MCU_MEM_TIMEOUT_EN undefined: no counter. The block waits indefinitely.

Test Plan:
- rst held 2 cycles with mem_ready = 1 -> all outputs 0 during reset. First cycle after release: state = 0, mem_req = 1, retire_cnt = 0.
- ADDI (opcode 0010011), mem_ready always 1 -> states 0,1,2,4,0. alu_op = 10, alu_src = 1 in EXEC. reg_write = 1 only in WB. retire_cnt = 1 after 4 cycles.
- LW (0000011, funct3 = 010), mem_ready low 3 cycles in MEM -> mem_req, iord = 1, mem_size = 10 held 4 cycles. WB has mem_to_reg = 1, reg_write = 1. Total 8 cycles.
- BEQ (1100011) followed by SW (0100011, funct3 = 000) -> BEQ: branch = 1, alu_op = 01 in EXEC, retire at 3 cycles. SW: mem_we = 1, mem_size = 00, never reg_write. retire_cnt = 2.
- Opcode 1111111 -> DECODE goes to HALT, halted = 1, all enables 0 for 10+ cycles. rst recovers to FETCH.
- Timeout: with MCU_MEM_TIMEOUT_EN, TIMEOUT_CYCLES = 4, mem_ready = 0 in FETCH -> HALT after 4 wait cycles. Without the macro -> remains in FETCH. CNT_W = 2 with 5 ADDIs -> retire_cnt wraps to 1.

Source files
------------

// File: rtl/multicycle_control_unit.sv
// Multi-cycle RV32I control FSM: FETCH/DECODE/EXEC/MEM/WB/HALT with retire counter.
// Optional memory wait timeout enabled by defining MCU_MEM_TIMEOUT_EN.
module multicycle_control_unit #(
  parameter int ALU_OP_W       = 2,
  parameter int CNT_W          = 32,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [6:0]          opcode,
  input  logic [2:0]          funct3,
  input  logic                mem_ready,
  output logic                mem_req,
  output logic                mem_we,
  output logic [1:0]          mem_size,
  output logic                iord,
  output logic                ir_write,
  output logic                pc_write,
  output logic [1:0]          pc_src,
  output logic                branch,
  output logic                alu_src,
  output logic [ALU_OP_W-1:0] alu_op,
  output logic                mem_to_reg,
  output logic                reg_write,
  output logic                lui,
  output logic                auipc,
  output logic                jal,
  output logic                jalr,
  output logic [2:0]          state,
  output logic                halted,
  output logic [CNT_W-1:0]    retire_cnt
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_HALT   = 3'd5
  } state_t;

  typedef enum logic [3:0] {
    C_NONE, C_R, C_I, C_LOAD, C_STORE,
    C_BRANCH, C_JAL, C_JALR, C_LUI, C_AUIPC
  } cls_t;

  localparam logic [ALU_OP_W-1:0] ALU_ADD = '0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB = ALU_OP_W'(1);
  localparam logic [ALU_OP_W-1:0] ALU_FN  = ALU_OP_W'(2);

  state_t           r_state;
  state_t           w_next;
  cls_t             r_cls;
  cls_t             w_dec_cls;
  logic             r_halted;
  logic [CNT_W-1:0] r_cnt;
  logic             w_retire;
  logic             w_tmo;
  logic             w_unused;

  assign w_unused = funct3[2];

  always_comb begin
    unique case (opcode)
      7'b0110011: w_dec_cls = C_R;
      7'b0010011: w_dec_cls = C_I;
      7'b0000011: w_dec_cls = C_LOAD;
      7'b0100011: w_dec_cls = C_STORE;
      7'b1100011: w_dec_cls = C_BRANCH;
      7'b1101111: w_dec_cls = C_JAL;
      7'b1100111: w_dec_cls = C_JALR;
      7'b0110111: w_dec_cls = C_LUI;
      7'b0010111: w_dec_cls = C_AUIPC;
      default:    w_dec_cls = C_NONE;
    endcase
  end

`ifdef MCU_MEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] r_wait;
  logic          w_busy;

  assign w_busy = (r_state == S_FETCH) || (r_state == S_MEM);
  // Fault on the TIMEOUT_CYCLES-th consecutive unanswered cycle.
  assign w_tmo  = w_busy && !mem_ready &&
                  (r_wait == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst || !w_busy || mem_ready) r_wait <= '0;
    else                             r_wait <= r_wait + 1'b1;
  end
`else
  localparam int UNUSED_TMO = TIMEOUT_CYCLES;
  assign w_tmo = 1'b0;
`endif

  always_comb begin
    w_next   = r_state;
    w_retire = 1'b0;
    case (r_state)
      S_FETCH: begin
        if (mem_ready)  w_next = S_DECODE;
        else if (w_tmo) w_next = S_HALT;
      end
      S_DECODE: w_next = (w_dec_cls == C_NONE) ? S_HALT : S_EXEC;
      S_EXEC: begin
        if (r_cls == C_LOAD || r_cls == C_STORE) begin
          w_next = S_MEM;
        end else if (r_cls == C_BRANCH) begin
          w_next   = S_FETCH;
          w_retire = 1'b1;
        end else begin
          w_next = S_WB;
        end
      end
      S_MEM: begin
        if (mem_ready) begin
          w_next   = (r_cls == C_LOAD) ? S_WB : S_FETCH;
          w_retire = (r_cls != C_LOAD);
        end else if (w_tmo) begin
          w_next = S_HALT;
        end
      end
      S_WB: begin
        w_next   = S_FETCH;
        w_retire = 1'b1;
      end
      default: w_next = S_HALT;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_FETCH;
      r_cls    <= C_NONE;
      r_halted <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_state <= w_next;
      if (r_state == S_DECODE) r_cls <= w_dec_cls;
      if (w_next == S_HALT)    r_halted <= 1'b1;
      if (w_retire)            r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    mem_size   = 2'b00;
    iord       = 1'b0;
    ir_write   = 1'b0;
    pc_write   = 1'b0;
    pc_src     = 2'b00;
    branch     = 1'b0;
    alu_src    = 1'b0;
    alu_op     = ALU_ADD;
    mem_to_reg = 1'b0;
    reg_write  = 1'b0;
    lui        = 1'b0;
    auipc      = 1'b0;
    jal        = 1'b0;
    jalr       = 1'b0;
    if (!rst) begin
      case (r_state)
        S_FETCH: begin
          mem_req  = 1'b1;
          mem_size = 2'b10;
          ir_write = mem_ready;
          pc_write = mem_ready;
        end
        S_EXEC: begin
          unique case (1'b1)
            r_cls == C_R:      alu_op = ALU_FN;
            r_cls == C_I: begin
              alu_op  = ALU_FN;
              alu_src = 1'b1;
            end
            r_cls == C_LOAD,
            r_cls == C_STORE:  alu_src = 1'b1;
            r_cls == C_BRANCH: begin
              alu_op = ALU_SUB;
              branch = 1'b1;
              pc_src = 2'b01;
            end
            r_cls == C_JAL: begin
              jal      = 1'b1;
              pc_write = 1'b1;
              pc_src   = 2'b01;
            end
            r_cls == C_JALR: begin
              jalr     = 1'b1;
              alu_src  = 1'b1;
              pc_write = 1'b1;
              pc_src   = 2'b10;
            end
            r_cls == C_LUI:    lui = 1'b1;
            r_cls == C_AUIPC: begin
              auipc   = 1'b1;
              alu_src = 1'b1;
            end
            default: ;
          endcase
        end
        S_MEM: begin
          mem_req  = 1'b1;
          iord     = 1'b1;
          mem_we   = (r_cls == C_STORE);
          mem_size = funct3[1:0];
        end
        S_WB: begin
          reg_write  = 1'b1;
          mem_to_reg = (r_cls == C_LOAD);
          lui        = (r_cls == C_LUI);
          auipc      = (r_cls == C_AUIPC);
          jal        = (r_cls == C_JAL);
          jalr       = (r_cls == C_JALR);
        end
        default: ;
      endcase
    end
  end

  assign state      = rst ? 3'd0 : r_state;
  assign halted     = r_halted && !rst;
  assign retire_cnt = rst ? '0 : r_cnt;

endmodule
